cv32e40p_instr_aligner: RTL and testbench

//  Sits between the prefetch buffer (32-bit word stream, valid/ready) and the IF/ID register.
//  Re-aligns RV32IC instructions that start on half-word boundaries or straddle two fetch words.

---
 rtl/cv32e40p_instr_aligner_pkg.sv | 12 +
 rtl/cv32e40p_instr_aligner.sv | 151 +++++++++++++++
 tb/tb_cv32e40p_instr_aligner.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_instr_aligner_pkg.sv
// Shared types for the RV32IC instruction aligner.
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        ALIGNED           = 2'd0,
        MISALIGNED        = 2'd1,
        BRANCH_MISALIGNED = 2'd2
    } aligner_state_e;

    localparam logic [1:0] OPC_32B = 2'b11;

endpackage

// File: rtl/cv32e40p_instr_aligner.sv
// Re-aligns a word-aligned fetch stream into one RV32IC instruction per handshake, tracking the PC.
module cv32e40p_instr_aligner
    import cv32e40p_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_aligned_o,
    output logic        instr_compressed_o,
    output logic [31:0] pc_o,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        hwlp_jump_i,
    input  logic [31:0] hwlp_target_i
);

    aligner_state_e r_state, w_state_n;
    logic [31:0]    r_pc, w_pc_n;
    logic [15:0]    r_hold, w_hold_n;
    logic           r_hwlp_pend, w_hwlp_pend_n;
    logic [31:0]    r_hwlp_tgt, w_hwlp_tgt_n;

    logic           w_accept;
    logic           w_jump;
    logic [31:0]    w_jump_tgt;
    logic           w_pop;

    // A latched loop jump keeps its own target; a fresh one uses the live input.
    assign w_jump     = r_hwlp_pend | hwlp_jump_i;
    assign w_jump_tgt = r_hwlp_pend ? r_hwlp_tgt : hwlp_target_i;
    assign w_accept   = instr_valid_o & instr_ready_i;

    always_comb begin
        w_state_n       = r_state;
        w_pc_n          = r_pc;
        w_hold_n        = r_hold;
        w_hwlp_pend_n   = r_hwlp_pend;
        w_hwlp_tgt_n    = r_hwlp_tgt;
        instr_valid_o   = 1'b0;
        instr_aligned_o = 32'h0;
        w_pop           = 1'b0;

        unique case (r_state)
            ALIGNED: begin
                if (fetch_valid_i) begin
                    instr_valid_o = 1'b1;
                    if (fetch_rdata_i[1:0] == OPC_32B) begin
                        instr_aligned_o = fetch_rdata_i;
                        if (instr_ready_i) begin
                            w_pc_n = r_pc + 32'd4;
                            w_pop  = 1'b1;
                        end
                    end else begin
                        instr_aligned_o = {16'h0, fetch_rdata_i[15:0]};
                        if (instr_ready_i) begin
                            w_hold_n  = fetch_rdata_i[31:16];
                            w_pc_n    = r_pc + 32'd2;
                            w_pop     = 1'b1;
                            w_state_n = MISALIGNED;
                        end
                    end
                end
            end
            MISALIGNED: begin
                if (r_hold[1:0] != OPC_32B) begin
                    instr_valid_o   = 1'b1;
                    instr_aligned_o = {16'h0, r_hold};
                    if (instr_ready_i) begin
                        w_pc_n    = r_pc + 32'd2;
                        w_state_n = ALIGNED;
                    end
                end else if (fetch_valid_i) begin
                    instr_valid_o   = 1'b1;
                    instr_aligned_o = {fetch_rdata_i[15:0], r_hold};
                    if (instr_ready_i) begin
                        w_hold_n = fetch_rdata_i[31:16];
                        w_pc_n   = r_pc + 32'd4;
                        w_pop    = 1'b1;
                    end
                end
            end
            BRANCH_MISALIGNED: begin
                if (fetch_valid_i) begin
                    if (fetch_rdata_i[17:16] != OPC_32B) begin
                        instr_valid_o   = 1'b1;
                        instr_aligned_o = {16'h0, fetch_rdata_i[31:16]};
                        if (instr_ready_i) begin
                            w_pc_n    = r_pc + 32'd2;
                            w_pop     = 1'b1;
                            w_state_n = ALIGNED;
                        end
                    end else if (instr_ready_i) begin
                        // Upper half starts a 32-bit instruction: park it, PC stays on it.
                        w_hold_n  = fetch_rdata_i[31:16];
                        w_pop     = 1'b1;
                        w_state_n = MISALIGNED;
                    end
                end
            end
            default: w_state_n = ALIGNED;
        endcase

        if (branch_i) begin
            instr_valid_o = 1'b0;
            w_pop         = 1'b0;
            w_pc_n        = branch_addr_i;
            w_hold_n      = 16'h0;
            w_hwlp_pend_n = 1'b0;
            w_state_n     = branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED;
        end else if (w_jump) begin
            if (w_accept) begin
                // Loop end retires now; the prefetcher already redirected, so keep its word.
                w_pop         = 1'b0;
                w_pc_n        = w_jump_tgt;
                w_hold_n      = 16'h0;
                w_hwlp_pend_n = 1'b0;
                w_state_n     = w_jump_tgt[1] ? BRANCH_MISALIGNED : ALIGNED;
            end else begin
                w_hwlp_pend_n = 1'b1;
                w_hwlp_tgt_n  = w_jump_tgt;
            end
        end
    end

    assign fetch_ready_o      = w_pop & fetch_valid_i;
    assign instr_compressed_o = (instr_aligned_o[1:0] != OPC_32B);
    assign pc_o               = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ALIGNED;
            r_pc        <= RESET_PC;
            r_hold      <= 16'h0;
            r_hwlp_pend <= 1'b0;
            r_hwlp_tgt  <= 32'h0;
        end else begin
            r_state     <= w_state_n;
            r_pc        <= w_pc_n;
            r_hold      <= w_hold_n;
            r_hwlp_pend <= w_hwlp_pend_n;
            r_hwlp_tgt  <= w_hwlp_tgt_n;
        end
    end

endmodule

// File: tb/tb_cv32e40p_instr_aligner.sv
// Directed bench for the instruction aligner: hand-computed instructions, PCs and pops.
module tb_cv32e40p_instr_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_aligned_o;
    logic        instr_compressed_o;
    logic [31:0] pc_o;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        hwlp_jump_i;
    logic [31:0] hwlp_target_i;

    int total = 0;
    int bad   = 0;

    cv32e40p_instr_aligner #(.RESET_PC(32'h0)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_rdata_i      (fetch_rdata_i),
        .fetch_ready_o      (fetch_ready_o),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i),
        .instr_aligned_o    (instr_aligned_o),
        .instr_compressed_o (instr_compressed_o),
        .pc_o               (pc_o),
        .branch_i           (branch_i),
        .branch_addr_i      (branch_addr_i),
        .hwlp_jump_i        (hwlp_jump_i),
        .hwlp_target_i      (hwlp_target_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs settle 1ns after inputs change, well away from the rising edge.
    task automatic settle();
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_branch(input logic [31:0] addr);
        branch_i      = 1'b1;
        branch_addr_i = addr;
        settle();
        chk("branch_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("branch_fready", {31'h0, fetch_ready_o}, 32'h0);
        step();
        branch_i = 1'b0;
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] ins,
                                input logic [31:0] pc, input logic pop);
        settle();
        chk({tag, "_valid"}, {31'h0, instr_valid_o}, 32'h1);
        chk({tag, "_instr"}, instr_aligned_o, ins);
        chk({tag, "_c"}, {31'h0, instr_compressed_o}, {31'h0, ins[1:0] != 2'b11});
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_pop"}, {31'h0, fetch_ready_o}, {31'h0, pop});
    endtask

    initial begin
        rst_n = 1'b0; fetch_valid_i = 1'b0; fetch_rdata_i = 32'h0;
        instr_ready_i = 1'b1; branch_i = 1'b0; branch_addr_i = 32'h0;
        hwlp_jump_i = 1'b0; hwlp_target_i = 32'h0;
        #12;
        chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst_fready", {31'h0, fetch_ready_o}, 32'h0);
        chk("rst_instr", instr_aligned_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        step();

        // T1: two aligned 32-bit instructions
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00A0_0093;
        do_branch(32'h100);
        expect_instr("t1a", 32'h00A0_0093, 32'h100, 1'b1); step();
        fetch_rdata_i = 32'h00B0_0113;
        expect_instr("t1b", 32'h00B0_0113, 32'h104, 1'b1); step();

        // T2: two compressed in one word, second needs no fetch
        do_branch(32'h200);
        fetch_rdata_i = 32'h4505_4501;
        expect_instr("t2a", 32'h0000_4501, 32'h200, 1'b1); step();
        fetch_valid_i = 1'b0;
        expect_instr("t2b", 32'h0000_4505, 32'h202, 1'b0); step();

        // T3: compressed then a straddling 32-bit instruction
        do_branch(32'h200);
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0093_4501;
        expect_instr("t3a", 32'h0000_4501, 32'h200, 1'b1); step();
        fetch_rdata_i = 32'h1234_00A0;
        expect_instr("t3b", 32'h00A0_0093, 32'h202, 1'b1); step();
        fetch_valid_i = 1'b0;
        expect_instr("t3c", 32'h0000_1234, 32'h206, 1'b0);

        // T5: back-pressure in MISALIGNED, branch on the third stalled cycle
        instr_ready_i = 1'b0; fetch_valid_i = 1'b1; fetch_rdata_i = 32'hDEAD_BEEF;
        expect_instr("t5s1", 32'h0000_1234, 32'h206, 1'b0); step();
        expect_instr("t5s2", 32'h0000_1234, 32'h206, 1'b0); step();
        expect_instr("t5s3", 32'h0000_1234, 32'h206, 1'b0);
        do_branch(32'h302);
        instr_ready_i = 1'b1;

        // T4: branch to a half-word target
        fetch_rdata_i = 32'h4581_FFFF;
        expect_instr("t4a", 32'h0000_4581, 32'h302, 1'b1); step();
        do_branch(32'h302);
        fetch_rdata_i = 32'h0093_FFFF;
        settle();
        chk("t4b_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("t4b_pop", {31'h0, fetch_ready_o}, 32'h1);
        step();
        fetch_valid_i = 1'b0;
        settle();
        chk("t4c_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("t4c_pc", pc_o, 32'h302);
        step();
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'hBEEF_00A0;
        expect_instr("t4d", 32'h00A0_0093, 32'h302, 1'b1); step();

        // T6: loop jump accepted in the same cycle
        do_branch(32'h500);
        fetch_rdata_i = 32'h00A0_0093;
        hwlp_jump_i = 1'b1; hwlp_target_i = 32'h400;
        expect_instr("t6a", 32'h00A0_0093, 32'h500, 1'b0); step();
        hwlp_jump_i = 1'b0; hwlp_target_i = 32'h0;
        expect_instr("t6b", 32'h00A0_0093, 32'h400, 1'b1); step();

        // T6 again with the end instruction stalled for two cycles
        do_branch(32'h500);
        instr_ready_i = 1'b0; hwlp_jump_i = 1'b1; hwlp_target_i = 32'h400;
        expect_instr("t6c", 32'h00A0_0093, 32'h500, 1'b0); step();
        hwlp_jump_i = 1'b0; hwlp_target_i = 32'h0;
        expect_instr("t6d", 32'h00A0_0093, 32'h500, 1'b0); step();
        instr_ready_i = 1'b1;
        expect_instr("t6e", 32'h00A0_0093, 32'h500, 1'b0); step();
        expect_instr("t6f", 32'h00A0_0093, 32'h400, 1'b1); step();

        // PC wrap from the top half-word
        do_branch(32'hFFFF_FFFE);
        fetch_rdata_i = 32'h4581_0000;
        expect_instr("wrap_a", 32'h0000_4581, 32'hFFFF_FFFE, 1'b1); step();
        fetch_rdata_i = 32'h00A0_0093;
        expect_instr("wrap_b", 32'h00A0_0093, 32'h0, 1'b1); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
